// File: rtl/mux_rr_scheduler_pkg.sv
// Shared types for the round-robin mux scheduler: FSM state encoding and requester count.
package mux_rr_scheduler_pkg;
    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/mux_rr_scheduler_pick.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last and returns the
// first requester found; the previous owner therefore wins only when it is the sole requester.
module rr_pick4
    import mux_rr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       last_i,
    output logic             any_o,
    output logic [1:0]       win_o
);
    logic [1:0] idx;

    always_comb begin
        any_o = |req_i;
        win_o = last_i;
        idx   = last_i;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int k = 4; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (req_i[idx]) begin
                win_o = idx;
            end
        end
    end
endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a 4:1 mux: one-hot grant plus sel, bounded hold time,
// and a mandatory one-cycle zero-grant gap between owners.
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       sel_o,
    output logic             busy_o,
    output logic             expired_o
);
    state_e           state_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N_REQ-1:0] gnt_q;
    logic [1:0]       sel_q;
    logic             busy_q;
    logic             expired_q;

    logic             pick_any;
    logic [1:0]       pick_win;
    logic             owner_req;
    logic             hold_done;

    rr_pick4 u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .any_o  (pick_any),
        .win_o  (pick_win)
    );

    assign cnt_d     = cnt_q + 1'b1;
    assign owner_req = req_i[last_q];
    assign hold_done = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            case (state_q)
                ST_GRANT: begin
                    // A voluntary drop takes precedence over hitting the hold limit.
                    if (!owner_req || hold_done) begin
                        state_q   <= ST_GAP;
                        gnt_q     <= '0;
                        expired_q <= owner_req;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    expired_q <= 1'b0;
                    if (pick_any) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= onehot4(pick_win);
                        sel_q   <= pick_win;
                        last_q  <= pick_win;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign expired_o = expired_q;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: behavioural owner/hold model checked every cycle, directed
// scenarios with literal expectations, then randomized requests with occasional resets.
module tb_mux_rr_scheduler;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       expired;

    logic [3:0] mux_in = 4'b1010;   // in0..in3 = 0,1,0,1

    int checks = 0;
    int errors = 0;

    mux_rr_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .busy_o    (busy),
        .expired_o (expired)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the mux, how long they've held it, and whether we're in the gap.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_sel   = 0;
    bit m_gap   = 0;
    bit m_exp   = 0;
    bit m_valid = 0;

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = 3; m_sel = 0; m_gap = 0; m_exp = 0;
            m_valid = 1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1; m_gap = 1; m_exp = 0;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1; m_gap = 1; m_exp = 1;
            end else begin
                m_held++;
            end
        end else begin
            int w;
            w = pick(req, m_last);
            m_exp = 0;
            m_gap = 0;
            if (w >= 0) begin
                m_owner = w; m_last = w; m_sel = w; m_held = 1;
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] e_gnt;
        if (!m_valid) return;
        e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("model_gnt", int'(gnt), int'(e_gnt));
        chk("model_sel", int'(sel), m_sel);
        chk("model_busy", int'(busy), int'(m_owner >= 0 || m_gap));
        chk("model_expired", int'(expired), int'(m_exp));
        chk("model_mux_out", int'(mux_in[sel]), int'(mux_in[m_sel[1:0]]));
        chk("inv_onehot0", int'($onehot0(gnt)), 1);
        if (gnt != 4'b0000) begin
            chk("inv_busy_when_gnt", int'(busy), 1);
            chk("inv_gnt_sel", int'(gnt[sel]), 1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int starts[$];
        int lens[$];
        int run;
        int exp_cnt;
        int cnt8;
        logic [3:0] prev;

        // Reset held two cycles with every requester active.
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_busy", int'(busy), 0);
        end

        // Single requester 2 for three cycles, then release.
        rst = 1'b0; req = 4'b0100;
        tick();
        chk("t2_gnt", int'(gnt), 4);
        chk("t2_sel", int'(sel), 2);
        chk("t2_mux", int'(mux_in[sel]), 0);
        tick(); tick();
        chk("t2_gnt3", int'(gnt), 4);
        req = 4'b0000;
        tick();
        chk("t2_gap_gnt", int'(gnt), 0);
        chk("t2_gap_busy", int'(busy), 1);
        tick();
        chk("t2_idle_busy", int'(busy), 0);

        // All four requesting: rotation 0,1,2,3,0 with full-length holds.
        do_reset();
        req = 4'b1111;
        prev = 4'b0000; run = 0; exp_cnt = 0;
        for (int i = 0; i < 44; i++) begin
            tick();
            if (expired) exp_cnt++;
            if (gnt != 4'b0000) begin
                if (prev == 4'b0000) starts.push_back(int'(sel));
                run++;
            end else if (prev != 4'b0000) begin
                lens.push_back(run);
                run = 0;
            end
            prev = gnt;
        end
        chk("t3_grants", starts.size(), 5);
        for (int i = 0; i < starts.size() && i < 5; i++)
            chk("t3_order", starts[i], i % 4);
        chk("t3_runs", lens.size(), 4);
        for (int i = 0; i < lens.size(); i++)
            chk("t3_len", lens[i], MAX_HOLD);
        chk("t3_expired", exp_cnt, 4);
        req = 4'b0000;
        tick(); tick();

        // Owner 1 drops while 0 still requests; then wrap-around from owner 3 to 0.
        do_reset();
        req = 4'b0010;
        tick();
        chk("t4_gnt1", int'(gnt), 2);
        tick();
        req = 4'b0001;
        tick();
        chk("t4_gap", int'(gnt), 0);
        chk("t4_gap_exp", int'(expired), 0);
        tick();
        chk("t4_gnt0", int'(gnt), 1);
        req = 4'b0000;
        tick(); tick();
        req = 4'b1000;
        tick();
        chk("t4_gnt3", int'(gnt), 8);
        req = 4'b0001;
        tick();
        chk("t4_gap2", int'(gnt), 0);
        tick();
        chk("t4_wrap", int'(gnt), 1);
        chk("t4_wrap_sel", int'(sel), 0);
        req = 4'b0000;
        tick(); tick();

        // Sole requester exceeding the hold limit is revoked then re-granted.
        do_reset();
        req = 4'b0100;
        cnt8 = 0;
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick();
            if (gnt == 4'b0100) cnt8++;
        end
        chk("t5_hold", cnt8, MAX_HOLD);
        tick();
        chk("t5_gap_gnt", int'(gnt), 0);
        chk("t5_gap_exp", int'(expired), 1);
        chk("t5_gap_busy", int'(busy), 1);
        tick();
        chk("t5_regrant", int'(gnt), 4);
        chk("t5_exp_clr", int'(expired), 0);
        req = 4'b0000;
        tick(); tick();

        // Reset in the middle of owner 3's grant.
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre", int'(gnt), 8);
        rst = 1'b1;
        tick();
        chk("t6_rst_gnt", int'(gnt), 0);
        chk("t6_rst_sel", int'(sel), 0);
        chk("t6_rst_busy", int'(busy), 0);
        rst = 1'b0; req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        chk("t6_gnt", int'(gnt), 8);
        chk("t6_sel", int'(sel), 3);

        // Randomized requests with sticky bits and rare resets.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            rst = ($urandom_range(63) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
